// File: rtl/dot_accum_pkg.sv
// Shared definitions for the dot-product accumulator controller.
//   DATA_W  : operand / result width
//   LEN_W   : default width of the element counter
//   ENTRY_W : width of one operand-queue entry {a, b, last}
package dot_accum_pkg;

    localparam int DATA_W  = 32;
    localparam int LEN_W   = 16;
    localparam int ENTRY_W = 2 * DATA_W + 1;

    // One queued operand pair. Keep in sync with ENTRY_W.
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              last;
    } opnd_t;

endpackage

// File: rtl/dot_accum_if.sv
// Streaming interface of the dot-product accumulator.
//   in_*  : operand-pair stream (valid/ready), in_last marks end of vector
//   out_* : result stream (valid/ready), out_data = dot product, out_len = count
// Modports:
//   slave  : the accumulator itself
//   master : the environment (producer of pairs, consumer of results)
interface dot_accum_if #(
    parameter int LEN_W = dot_accum_pkg::LEN_W
) ();

    logic                              in_valid;
    logic                              in_ready;
    logic [dot_accum_pkg::DATA_W-1:0]  in_a;
    logic [dot_accum_pkg::DATA_W-1:0]  in_b;
    logic                              in_last;
    logic                              out_valid;
    logic                              out_ready;
    logic [dot_accum_pkg::DATA_W-1:0]  out_data;
    logic [LEN_W-1:0]                  out_len;

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_data, out_len
    );

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_len
    );

endinterface

// File: rtl/dot_opnd_fifo.sv
// Synchronous operand FIFO with full/empty flags.
//   clk, rst_n : clock, async active-low reset (clears pointers only)
//   push/wdata : write when push && !full
//   pop        : drop head when pop && !empty
//   rdata      : current head entry (valid when !empty)
//   full/empty : occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module dot_opnd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = dot_accum_pkg::ENTRY_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        rdata    = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is not reset; an entry is only read after it was written,
    // and leaving it unreset keeps it a plain RAM/register array.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/dot_accum_ctrl.sv
// Dot-product accumulation controller around an external 1-cycle MADD unit.
//   clk, rst_n   : clock, async active-low reset
//   io (slave)   : operand stream in, dot-product result stream out
//   madd_a/b     : A/B operands for the MADD, presented in issue cycle t
//   madd_c       : C addend for the MADD, presented in cycle t+1
//   madd_z       : MADD result A(t)*B(t)+C(t+1), valid combinationally in t+1
// Pairs are queued, issued one per cycle, and the running sum is fed back
// through C. A vector's final element is held back while the result register
// cannot take a new value, or while the previous last is still in flight.
module dot_accum_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = dot_accum_pkg::LEN_W
) (
    input  logic                clk,
    input  logic                rst_n,
    dot_accum_if.slave          io,
    output logic [31:0]         madd_a,
    output logic [31:0]         madd_b,
    output logic [31:0]         madd_c,
    input  logic [31:0]         madd_z
);

    import dot_accum_pkg::*;

    localparam logic [LEN_W-1:0] CNT_MAX = '1;

    opnd_t             push_entry;
    opnd_t             head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              out_free;
    logic              issue;

    logic              issue_d1_q, issue_d1_d;
    logic              last_d1_q,  last_d1_d;
    logic              first_q,    first_d;     // next issued element starts a vector
    logic              first_d1_q, first_d1_d;  // element in flight started a vector
    logic [LEN_W-1:0]  cnt_q,      cnt_d;
    logic [DATA_W-1:0] acc_q,      acc_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [LEN_W-1:0]  out_len_q,   out_len_d;

    assign push_entry = '{a: io.in_a, b: io.in_b, last: io.in_last};

    dot_opnd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (io.in_valid),
        .wdata (push_entry),
        .pop   (issue),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign io.in_ready  = !fifo_full;
    assign io.out_valid = out_valid_q;
    assign io.out_data  = out_data_q;
    assign io.out_len   = out_len_q;

    // Issue and MADD operand selection.
    always_comb begin
        out_free = !out_valid_q || io.out_ready;
        issue    = !fifo_empty && (!head.last || (out_free && !last_d1_q));
        madd_a   = issue ? head.a : '0;
        madd_b   = issue ? head.b : '0;
        madd_c   = (issue_d1_q && !first_d1_q) ? acc_q : '0;
    end

    // Next-state logic.
    // NOTE: every target gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        issue_d1_d  = issue;
        last_d1_d   = issue && head.last;
        first_d1_d  = first_q;
        first_d     = first_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_len_d   = out_len_q;

        if (issue) begin
            first_d = head.last;
            cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end

        if (out_valid_q && io.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (issue_d1_q) begin
            acc_d = madd_z;
            if (last_d1_q) begin
                out_valid_d = 1'b1;
                out_data_d  = madd_z;
                out_len_d   = cnt_q;
                // An element issued this cycle already belongs to the next vector.
                cnt_d       = {{(LEN_W-1){1'b0}}, issue};
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_d1_q  <= 1'b0;
            last_d1_q   <= 1'b0;
            first_q     <= 1'b1;
            first_d1_q  <= 1'b1;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_len_q   <= '0;
        end else begin
            issue_d1_q  <= issue_d1_d;
            last_d1_q   <= last_d1_d;
            first_q     <= first_d;
            first_d1_q  <= first_d1_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_len_q   <= out_len_d;
        end
    end

endmodule

// File: tb/tb_dot_accum_ctrl.sv
// Self-checking bench for dot_accum_ctrl with a behavioural MADD model.
// Expected results come from a plain arithmetic model of each vector
// (sum of products mod 2^32, saturating element count) pushed into a queue;
// a monitor pops and compares on every output handshake.
module tb_dot_accum_ctrl;

    import dot_accum_pkg::*;

    localparam int FIFO_DEPTH = 4;
    localparam int TB_LEN_W   = 16;
    localparam int CNT_LIMIT  = (1 << TB_LEN_W) - 1;

    typedef struct {
        logic [31:0]         data;
        logic [TB_LEN_W-1:0] len;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] madd_a, madd_b, madd_c, madd_z;
    logic [31:0] prod_q = '0;

    dot_accum_if #(.LEN_W(TB_LEN_W)) bus ();

    dot_accum_ctrl #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .LEN_W      (TB_LEN_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io     (bus.slave),
        .madd_a (madd_a),
        .madd_b (madd_b),
        .madd_c (madd_c),
        .madd_z (madd_z)
    );

    always #5 clk = ~clk;

    // External MADD: product registered, C added combinationally next cycle.
    always @(posedge clk) prod_q <= madd_a * madd_b;
    assign madd_z = prod_q + madd_c;

    int          n_checks = 0;
    int          n_pass   = 0;
    exp_t        exp_q[$];
    logic [31:0] m_sum = '0;
    int          m_cnt = 0;
    int          n_vec = 0;
    int          n_out = 0;
    int          stalls = 0;
    int          rdy_mode = 0;   // 0: always ready, 1: random, 2: never
    logic [31:0] last_data;
    logic [TB_LEN_W-1:0] last_len;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: fold one accepted pair into the current vector.
    function automatic void model_accept(input logic [31:0] a, input logic [31:0] b, input logic last);
        exp_t e;
        m_sum = m_sum + a * b;
        if (m_cnt < CNT_LIMIT) m_cnt++;
        if (last) begin
            e.data = m_sum;
            e.len  = TB_LEN_W'(m_cnt);
            exp_q.push_back(e);
            n_vec++;
            m_sum = '0;
            m_cnt = 0;
        end
    endfunction

    // Consumer readiness, updated 2 time units after each rising edge.
    always begin
        @(posedge clk);
        #2;
        case (rdy_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b0;
        endcase
    end

    // Monitor: compare on handshake, check hold-stability while stalled.
    logic        prev_valid = 1'b0;
    logic        prev_hs    = 1'b0;
    logic [31:0] prev_data;
    logic [TB_LEN_W-1:0] prev_len;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (prev_valid && !prev_hs) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_data",  bus.out_data,  prev_data);
                check("hold_len",   bus.out_len,   prev_len);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_data", bus.out_data, e.data);
                    check("out_len",  bus.out_len,  e.len);
                end
                last_data = bus.out_data;
                last_len  = bus.out_len;
                n_out++;
            end
            prev_valid = bus.out_valid;
            prev_hs    = bus.out_valid && bus.out_ready;
            prev_data  = bus.out_data;
            prev_len   = bus.out_len;
        end
    end

    // Offer one pair starting just after a rising edge; returns just after
    // the edge on which it was accepted.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        for (int w = 0; w < 300; w++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                model_accept(a, b, last);
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                return;
            end
            stalls++;
            @(posedge clk);
            #1;
        end
        check("send_timeout", 0, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(posedge clk);
        idle(3);
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int base;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state.
        #12;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data",  bus.out_data,  0);
        check("rst_out_len",   bus.out_len,   0);
        rst_n = 1'b1;
        idle(2);
        check("rst_in_ready", bus.in_ready, 1);

        // (3,4),(5,6,last): 42, len 2, valid two edges after the last accept.
        send(32'd3, 32'd4, 1'b0);
        send(32'd5, 32'd6, 1'b1);
        @(negedge clk); check("lat_e0p1_low",  bus.out_valid, 0);
        @(negedge clk); check("lat_e0p2_low",  bus.out_valid, 0);
        @(negedge clk); check("lat_e0p2_high", bus.out_valid, 1);
        @(posedge clk); #1;
        drain();
        check("v42_data", last_data, 42);
        check("v42_len",  last_len,  2);

        // All-ones squared wraps to 1.
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        drain();
        check("wrap_data", last_data, 1);
        check("wrap_len",  last_len,  1);

        // Stalled output: 6 held, second last blocked, then 6 and 49.
        rdy_mode = 2;
        base = n_out;
        send(32'd2, 32'd3, 1'b1);
        send(32'd7, 32'd7, 1'b1);
        idle(6);
        @(negedge clk);
        check("stall_valid", bus.out_valid, 1);
        check("stall_data",  bus.out_data,  6);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("blocked_madd_a", madd_a, 0);
            check("blocked_madd_b", madd_b, 0);
        end
        @(posedge clk); #1;
        rdy_mode = 0;
        drain();
        check("stall_delivered", n_out - base, 2);
        check("stall_second", last_data, 49);

        // Eight back-to-back pairs: no stall, 204, len 8.
        stalls = 0;
        for (int i = 1; i <= 8; i++) send(32'(i), 32'(i), 1'(i == 8));
        check("b2b_no_stall", stalls, 0);
        drain();
        check("b2b_data", last_data, 204);
        check("b2b_len",  last_len,  8);

        // Backpressure: output held, last at head, queue fills.
        rdy_mode = 2;
        send(32'd1, 32'd1, 1'b1);
        idle(4);
        send(32'd2, 32'd2, 1'b1);
        send(32'd3, 32'd3, 1'b0);
        send(32'd4, 32'd4, 1'b0);
        send(32'd5, 32'd5, 1'b1);
        @(negedge clk);
        check("full_in_ready_low", bus.in_ready, 0);
        @(posedge clk); #1;
        rdy_mode = 0;
        @(negedge clk); check("pop_cycle_in_ready_low", bus.in_ready, 0);
        @(negedge clk); check("after_pop_in_ready",     bus.in_ready, 1);
        @(posedge clk); #1;
        drain();
        check("bp_last_data", last_data, 50);

        // Reset mid-vector discards partial state.
        send(32'd9, 32'd9, 1'b0);
        send(32'd10, 32'd10, 1'b0);
        rst_n = 1'b0;
        m_sum = '0;
        m_cnt = 0;
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_in_ready",  bus.in_ready,  1);
        @(posedge clk); #1;
        send(32'd1, 32'd1, 1'b1);
        drain();
        check("post_rst_data", last_data, 1);
        check("post_rst_len",  last_len,  1);

        // Randomized vectors with random gaps and random consumer readiness.
        rdy_mode = 1;
        for (int v = 0; v < 40; v++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int e = 0; e < len; e++) begin
                logic [31:0] a, b;
                a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
                b = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
                send(a, b, 1'(e == len - 1));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        rdy_mode = 0;
        drain();
        check("all_delivered", n_out, n_vec);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dot_accum_ctrl.md
DOT_ACCUM_CTRL -- requirements
Module: dot_accum_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, operand queue entries (power of 2, >=2).
REQ-002 Parameter LEN_W, default 16, width of the element counter.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST_N  input  1  reset, asynchronous assertion, active-low.
REQ-005 in_valid  input  1  operand pair offered.
REQ-006 in_ready  output  1  operand pair accepted when in_valid && in_ready.
REQ-007 in_a, in_b  input  32 each  multiplicand and multiplier.
REQ-008 in_last  input  1  pair is final element of the current vector.
REQ-009 madd_a, madd_b  output  32 each  drive MADD A/B ports.
REQ-010 madd_c  output  32  drives MADD C port.
REQ-011 madd_z  input  32  MADD Z result.
REQ-012 out_valid  output  1  dot-product result available.
REQ-013 out_ready  input  1  consumer accepts when out_valid && out_ready.
REQ-014 out_data  output  32  dot product, mod 2^32.
REQ-015 out_len  output  LEN_W  element count of the vector.

Function
REQ-016 Accepted pairs enter a FIFO_DEPTH-entry queue {a, b, last}. in_ready = !full, with no push-through when full.
REQ-017 Issue occurs in a cycle when the queue is non-empty and, if the head has last=1, the last-issue rule (REQ-021) holds. On issue, the head drives madd_a/madd_b and pops at the next edge.
REQ-018 Without an issue, madd_a = madd_b = 0.
REQ-019 MADD timing contract:
- A/B are presented in cycle t.
- C must be presented in cycle t+1.
- Z = A(t)*B(t) + C(t+1) is valid combinationally in cycle t+1.
REQ-020 Accumulation:
- issue_d1 (registered issue) gates all use of madd_z.
- madd_c = 0 if the element in flight is first of its vector, else acc.
- acc <= madd_z at the end of cycle t+1.
- This gives back-to-back throughput of 1 element per cycle.
REQ-021 Last-issue rule: a last element issues only if (!out_valid || out_ready) && !last_d1.
REQ-022 When last_d1 is set, at the end of cycle t+1:
- out_data <= madd_z and out_valid <= 1.
- out_len <= element count.
- the count and the first-flag restart for the next vector.
REQ-023 The element counter increments per issued element and saturates at 2^LEN_W-1.
REQ-024 out_valid holds, with out_data and out_len stable, until the handshake; it clears on the handshake edge unless reloaded on that same edge.
REQ-025 Arithmetic is the low 32 bits only, identical for signed and unsigned operands; overflow wraps silently.
REQ-026 Latency: a last element accepted at edge E0, with the queue otherwise empty and no stall, yields out_valid high after edge E0+2.
REQ-027 Simultaneous push and pop on a non-full queue keeps the occupancy unchanged.

Reset
REQ-028 RST_N low asynchronously clears:
- queue pointers/occupancy, issue_d1, last_d1, the first-flag (set to 1), the counter, and acc (0);
- out_valid=0, out_data=0, out_len=0.
- in_ready reads 1 once reset is released.
REQ-029 Reset mid-vector discards all queued and in-flight elements. The stale MADD pipeline register is ignored because issue_d1=0.

Structure
REQ-030 Shared package dot_accum_pkg holds DATA_W=32, LEN_W, and the queue entry width (2*DATA_W+1).
REQ-031 The operand queue is one sub-module, dot_opnd_fifo (sync FIFO, full/empty flags); all remaining logic is in dot_accum_ctrl.
REQ-032 The MADD instance sits outside this block; connections are madd_a/b/c to A/B/C and Z to madd_z, on the same CLK.

Verification
REQ-033 Pairs (3,4),(5,6,last), out_ready=1 -> out_data=42, out_len=2, out_valid high 2 edges after the last is accepted.
REQ-034 Single pair (0xFFFFFFFF,0xFFFFFFFF,last) -> out_data=0x00000001, out_len=1.
REQ-035 out_ready=0; vectors (2,3,last) then (7,7,last):
- 6 is held stable and the second last does not issue;
- after out_ready=1, 6 then 49 are delivered with none lost.
REQ-036 8 pairs (i,i) for i=1..8 on consecutive cycles, last on i=8 -> in_ready stays 1, out_data=204, out_len=8.
REQ-037 out_ready=0 with a full output register and a last at the head -> in_ready drops after FIFO_DEPTH further accepts and recovers one cycle after the pop.
REQ-038 RST_N pulsed after 2 elements of a vector are accepted, then (1,1,last) -> out_data=1, out_len=1, with no contribution from pre-reset data.
